// File: rtl/can_fd_seq_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// can_fd_seq_pkg - state encoding, register map and init table for the CAN-FD APB sequencer. Rev 1.0
// ---------------------------------------------------------------------------
package can_fd_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_I_SETUP  = 4'd1,
    ST_I_ACCESS = 4'd2,
    ST_READY    = 4'd3,
    ST_T_SETUP  = 4'd4,
    ST_T_ACCESS = 4'd5,
    ST_C_SETUP  = 4'd6,
    ST_C_ACCESS = 4'd7,
    ST_R_SETUP  = 4'd8,
    ST_R_ACCESS = 4'd9,
    ST_ERR      = 4'd10
  } seq_state_e;

  localparam logic [31:0] CMD_ADDR     = 32'h0000_000C;
  localparam logic [31:0] TXT_BUF_ADDR = 32'h0000_0100;
  localparam logic [31:0] RX_DATA_ADDR = 32'h0000_006C;
  localparam logic [31:0] TX_CMD_VAL   = 32'h0000_0002;

  // MODE, BTR, BTR_FD, SETTINGS; unused slots stay zero
  localparam logic [31:0] INIT_ADDR [16] = '{
    32'h0000_0004, 32'h0000_0024, 32'h0000_0028, 32'h0000_0008,
    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
    32'h0, 32'h0, 32'h0, 32'h0
  };
  localparam logic [31:0] INIT_DATA [16] = '{
    32'h0000_0010, 32'h0204_0A05, 32'h0102_0403, 32'h0000_0001,
    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
    32'h0, 32'h0, 32'h0, 32'h0
  };

  function automatic logic st_access(input seq_state_e s);
    return (s == ST_I_ACCESS) || (s == ST_T_ACCESS) ||
           (s == ST_C_ACCESS) || (s == ST_R_ACCESS);
  endfunction

  function automatic logic st_busy(input seq_state_e s);
    return st_access(s) || (s == ST_I_SETUP) || (s == ST_T_SETUP) ||
           (s == ST_C_SETUP) || (s == ST_R_SETUP);
  endfunction

endpackage
`default_nettype wire

// File: rtl/can_fd_seq_rr_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// can_fd_seq_rr_arb - two-input round-robin arbiter, TX wins the first tie. Rev 1.0
// ---------------------------------------------------------------------------
module can_fd_seq_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid_i,
  input  logic       rd_valid_i,
  input  logic       en_i,
  output logic [1:0] grant_o      // [0] = TX, [1] = RD
);

  logic last_tx_q;

  always_comb begin
    grant_o = 2'b00;
    if (en_i) begin
      if (tx_valid_i && (!rd_valid_i || !last_tx_q)) grant_o = 2'b01;
      else if (rd_valid_i)                           grant_o = 2'b10;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    last_tx_q <= 1'b0;
    else if (grant_o != 2'b00)  last_tx_q <= grant_o[0];
  end

endmodule
`default_nettype wire

// File: rtl/can_fd_apb_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// can_fd_apb_sequencer - init-table replay then TX/RX-poll APB master (option: CAN_FD_SEQ_TIMEOUT_EN). Rev 1.0
// ---------------------------------------------------------------------------
module can_fd_apb_sequencer
  import can_fd_seq_pkg::*;
#(
  parameter int APB_ADDR_W = 12,
  parameter int INIT_LEN   = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  init_done,
  output logic                  busy,
  output logic                  error,
  input  logic                  tx_valid,
  input  logic [31:0]           tx_data,
  output logic                  tx_ready,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  output logic [31:0]           rd_data,
  output logic                  rd_data_valid,
  output logic [APB_ADDR_W-1:0] m_apb_paddr,
  output logic                  m_apb_psel,
  output logic                  m_apb_penable,
  output logic                  m_apb_pwrite,
  output logic [31:0]           m_apb_pwdata,
  output logic [3:0]            m_apb_pstrb,
  input  logic                  m_apb_pready,
  input  logic [31:0]           m_apb_prdata,
  input  logic                  m_apb_pslverr
);

  seq_state_e            state_q;
  logic [3:0]            idx_q;
  logic [3:0]            idx_d;
  logic [APB_ADDR_W-1:0] paddr_q;
  logic [31:0]           pwdata_q;
  logic [31:0]           rd_data_q;
  logic [3:0]            pstrb_q;
  logic                  psel_q, penable_q, pwrite_q;
  logic                  init_done_q, error_q, rd_data_valid_q;
  logic [1:0]            grant;
  logic                  in_access, fault, tmo_hit, last_init;

  function automatic logic [APB_ADDR_W-1:0] fit_addr(input logic [31:0] a);
    return a[APB_ADDR_W-1:0];
  endfunction

  assign in_access = st_access(state_q);
  assign fault     = in_access && m_apb_pready && m_apb_pslverr;
  assign idx_d     = idx_q + 4'd1;
  assign last_init = ({28'd0, idx_q} >= 32'(INIT_LEN - 1));

  can_fd_seq_rr_arb u_arb (
    .clk        (clk),
    .rst        (rst),
    .tx_valid_i (tx_valid),
    .rd_valid_i (rd_valid),
    .en_i       (state_q == ST_READY),
    .grant_o    (grant)
  );

`ifdef CAN_FD_SEQ_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] tmo_q;

  // Held at zero outside ACCESS, so every ACCESS state starts counting afresh
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                tmo_q <= '0;
    else if (!in_access)    tmo_q <= '0;
    else if (!m_apb_pready) tmo_q <= tmo_q + 8'd1;
  end

  assign tmo_hit = in_access && !m_apb_pready && (tmo_q == TMO_LAST);
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign tmo_hit        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      idx_q           <= '0;
      paddr_q         <= '0;
      pwdata_q        <= '0;
      pstrb_q         <= '0;
      psel_q          <= 1'b0;
      penable_q       <= 1'b0;
      pwrite_q        <= 1'b0;
      init_done_q     <= 1'b0;
      error_q         <= 1'b0;
      rd_data_q       <= '0;
      rd_data_valid_q <= 1'b0;
    end else begin
      rd_data_valid_q <= 1'b0;
      if (fault || tmo_hit) begin
        state_q   <= ST_ERR;
        psel_q    <= 1'b0;
        penable_q <= 1'b0;
        error_q   <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: if (start) begin
            state_q  <= ST_I_SETUP;
            idx_q    <= '0;
            paddr_q  <= fit_addr(INIT_ADDR[0]);
            pwdata_q <= INIT_DATA[0];
            pstrb_q  <= 4'hF;
            pwrite_q <= 1'b1;
            psel_q   <= 1'b1;
          end
          ST_I_SETUP: begin state_q <= ST_I_ACCESS; penable_q <= 1'b1; end
          ST_T_SETUP: begin state_q <= ST_T_ACCESS; penable_q <= 1'b1; end
          ST_C_SETUP: begin state_q <= ST_C_ACCESS; penable_q <= 1'b1; end
          ST_R_SETUP: begin state_q <= ST_R_ACCESS; penable_q <= 1'b1; end
          ST_I_ACCESS: if (m_apb_pready) begin
            penable_q <= 1'b0;
            if (last_init) begin
              state_q     <= ST_READY;
              psel_q      <= 1'b0;
              init_done_q <= 1'b1;
            end else begin
              state_q  <= ST_I_SETUP;
              idx_q    <= idx_d;
              paddr_q  <= fit_addr(INIT_ADDR[idx_d]);
              pwdata_q <= INIT_DATA[idx_d];
            end
          end
          ST_READY: begin
            // tx_data is captured straight into the write-data register on grant
            if (grant[0]) begin
              state_q  <= ST_T_SETUP;
              paddr_q  <= fit_addr(TXT_BUF_ADDR);
              pwdata_q <= tx_data;
              pstrb_q  <= 4'hF;
              pwrite_q <= 1'b1;
              psel_q   <= 1'b1;
            end else if (grant[1]) begin
              state_q  <= ST_R_SETUP;
              paddr_q  <= fit_addr(RX_DATA_ADDR);
              pwdata_q <= '0;
              pstrb_q  <= 4'h0;
              pwrite_q <= 1'b0;
              psel_q   <= 1'b1;
            end
          end
          ST_T_ACCESS: if (m_apb_pready) begin
            state_q   <= ST_C_SETUP;
            penable_q <= 1'b0;
            paddr_q   <= fit_addr(CMD_ADDR);
            pwdata_q  <= TX_CMD_VAL;
          end
          ST_C_ACCESS: if (m_apb_pready) begin
            state_q   <= ST_READY;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
          end
          ST_R_ACCESS: if (m_apb_pready) begin
            state_q         <= ST_READY;
            psel_q          <= 1'b0;
            penable_q       <= 1'b0;
            rd_data_q       <= m_apb_prdata;
            rd_data_valid_q <= 1'b1;
          end
          ST_ERR:  state_q <= ST_ERR;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign init_done     = init_done_q;
  assign busy          = st_busy(state_q);
  assign error         = error_q;
  assign tx_ready      = grant[0];
  assign rd_ready      = grant[1];
  assign rd_data       = rd_data_q;
  assign rd_data_valid = rd_data_valid_q;
  assign m_apb_paddr   = paddr_q;
  assign m_apb_psel    = psel_q;
  assign m_apb_penable = penable_q;
  assign m_apb_pwrite  = pwrite_q;
  assign m_apb_pwdata  = pwdata_q;
  assign m_apb_pstrb   = pstrb_q;

endmodule
`default_nettype wire

// File: doc/can_fd_apb_sequencer.md
Name: can_fd_apb_sequencer

Overview:
APB master that configures and then time-shares one can_fd_top_apb register interface. After `start` it replays a fixed init table of register writes. It then arbitrates between a TX requester (frame word write plus TX command) and an RX poll requester (single read). It sits between the liteCAN receive path and the CAN-FD core, replacing direct drive of pwrite/psel/penable.

Parameters:
APB_ADDR_W, 12, APB address width.
INIT_LEN, 4, number of init-table writes (1..16).
TIMEOUT, 255, max ACCESS cycles without pready (used only with the optional feature).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  begin init sequence; sampled only in IDLE
init_done  out  1  high from end of init until reset
busy  out  1  high in any SETUP/ACCESS state
error  out  1  sticky fault flag
tx_valid  in  1  TX request
tx_data  in  32  TX word; held stable while tx_valid=1 and tx_ready=0
tx_ready  out  1  combinational accept pulse
rd_valid  in  1  RX poll request
rd_ready  out  1  combinational accept pulse
rd_data  out  32  last read word
rd_data_valid  out  1  one-cycle pulse
m_apb_paddr  out  APB_ADDR_W  APB address
m_apb_psel  out  1  APB select
m_apb_penable  out  1  APB enable
m_apb_pwrite  out  1  APB write strobe
m_apb_pwdata  out  32  APB write data
m_apb_pstrb  out  4  APB byte strobes
m_apb_pready  in  1  APB ready
m_apb_prdata  in  32  APB read data
m_apb_pslverr  in  1  APB slave error

Behaviour:
- Reset state: IDLE. All outputs 0: paddr, pwdata, pstrb, psel, penable, pwrite, init_done, busy, error, rd_data, rd_data_valid, tx_ready, rd_ready.
- rst asserted mid-transfer: psel and penable drop asynchronously. The transfer is abandoned and not replayed.
- States: IDLE, I_SETUP, I_ACCESS, READY, T_SETUP, T_ACCESS, C_SETUP, C_ACCESS, R_SETUP, R_ACCESS, ERR.
- IDLE: if start=1, go to I_SETUP with init index 0. start in any other state is ignored.
- SETUP states: psel=1, penable=0, address/data/pwrite/pstrb valid. Always one cycle, then the matching ACCESS state.
- ACCESS states: psel=1, penable=1, all signals held until pready=1.
- Write transfers: pstrb=4'hF. Read transfers: pwrite=0, pstrb=0, pwdata=0.
- Outside SETUP/ACCESS: psel=penable=0; paddr and pwdata hold their last values.
- I_ACCESS with pready=1:
  - index<INIT_LEN-1: increment index, go to I_SETUP.
  - Otherwise: go to READY and set init_done=1 in the next cycle.
- Init timing with zero-wait slave: start sampled at cycle 0, init_done=1 at cycle 2*INIT_LEN+1.
- READY arbitration, decided in the same cycle:
  - Only tx_valid: grant TX. Only rd_valid: grant RD.
  - Both valid: grant the requester not served last. last_grant resets to RD, so TX wins the first tie.
  - Grant produces tx_ready (or rd_ready) =1 that cycle, combinationally from state==READY and grant. tx_data is latched on grant.
- TX sequence: T_SETUP/T_ACCESS write tx_data to TXT_BUF_ADDR, then C_SETUP/C_ACCESS write TX_CMD_VAL to CMD_ADDR, then READY.
  - Zero-wait cost: 5 cycles from grant to next grant opportunity.
- RD sequence: R_SETUP/R_ACCESS read RX_DATA_ADDR. When pready=1, rd_data<=prdata, rd_data_valid=1 the next cycle (coinciding with READY).
- pslverr=1 with pready=1 in any ACCESS state: go to ERR and set error=1.
  - ERR is terminal until rst: no APB traffic, tx_ready=rd_ready=0, init_done retains its value.
- busy=1 exactly in SETUP/ACCESS states.

Optional Feature:
CAN_FD_SEQ_TIMEOUT_EN.
- Defined: an 8-bit counter clears on entry to each ACCESS state and increments each ACCESS cycle with pready=0. On reaching TIMEOUT it goes to ERR, sets error=1, and deasserts psel/penable the next cycle.
- Undefined: ACCESS waits indefinitely. Counter and logic are absent.

Decomposition:
- Package can_fd_seq_pkg holds:
  - state encoding (4-bit localparams);
  - CMD_ADDR, TXT_BUF_ADDR, RX_DATA_ADDR;
  - TX_CMD_VAL;
  - INIT_ADDR[0..15] and INIT_DATA[0..15] table constants.
- Default table: MODE 0x004 ← 0x0000_0010, BTR 0x024 ← 0x0204_0A05, BTR_FD 0x028 ← 0x0102_0403, SETTINGS 0x008 ← 0x0000_0001.
- One sub-module, can_fd_seq_rr_arb: two-input round-robin with the last_grant register. Inputs valid, rd_valid, and an enable driven by READY; outputs one-hot grant.

Test Plan:
- Init, pready tied 1, start pulse at cycle 0 -> four writes in order to 0x004/0x024/0x028/0x008 with table data, pstrb=F; init_done=1 at cycle 9; busy low afterwards.
- TX, tx_valid with tx_data=0x0000_00A5 -> tx_ready pulse; write 0x0000_00A5 @TXT_BUF_ADDR, then TX_CMD_VAL @CMD_ADDR; READY 5 cycles after grant.
- Tie, tx_valid and rd_valid held high for three grants -> grant order TX, RD, TX; a read with prdata=0x1234_5678 yields rd_data=0x1234_5678 with a 1-cycle rd_data_valid.
- Wait states, pready low 3 cycles in T_ACCESS -> paddr/pwdata/psel/penable stable for 4 ACCESS cycles; no second tx_ready.
- Fault, pslverr=1 on init write 2 -> error=1 sticky, init_done=0, no further psel, tx_valid ignored. With CAN_FD_SEQ_TIMEOUT_EN and pready=0 -> error after 255 ACCESS cycles.
- Reset mid-transfer, rst pulsed in C_ACCESS -> all outputs 0 immediately; after release, state IDLE; start re-runs the full init.
